// File: rtl/resp_checker.sv
// Response checker: compares observed DUT values, in order, against expected values
// queued in a small FIFO, keeping pass/fail counts and the first mismatching pair.
module resp_checker #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int NUM_CHECKS = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [WIDTH-1:0] exp_data,
    input  logic             obs_valid,
    output logic             obs_ready,
    input  logic [WIDTH-1:0] obs_data,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [WIDTH-1:0] err_exp,
    output logic [WIDTH-1:0] err_obs,
    output logic             busy,
    output logic             done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(NUM_CHECKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [CNT_W-1:0] total_r;
    logic [CNT_W-1:0] pass_cnt_r;
    logic [CNT_W-1:0] fail_cnt_r;
    logic             err_r;
    logic [WIDTH-1:0] err_exp_r;
    logic [WIDTH-1:0] err_obs_r;

    logic             in_run_s;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic             arm_s;
    logic             last_s;
    logic [CNT_W-1:0] total_inc_s;
    logic [WIDTH-1:0] head_s;

    // Extra pointer MSB separates full from empty when the index bits agree.
    assign empty_s     = (wr_ptr_r == rd_ptr_r);
    assign full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                         (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign in_run_s    = (state_r == ST_RUN);
    assign push_s      = in_run_s && exp_valid && !full_s;
    assign pop_s       = in_run_s && obs_valid && !empty_s;
    assign arm_s       = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign total_inc_s = total_r + CNT_ONE;
    assign last_s      = pop_s && (total_inc_s == CNT_TARGET);
    assign head_s      = mem_r[rd_ptr_r[AW-1:0]];

    assign exp_ready = in_run_s && !full_s;
    assign obs_ready = in_run_s && !empty_s;
    assign busy      = in_run_s;
    assign done      = (state_r == ST_DONE);
    assign pass_cnt  = pass_cnt_r;
    assign fail_cnt  = fail_cnt_r;
    assign err       = err_r;
    assign err_exp   = err_exp_r;
    assign err_obs   = err_obs_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nx_s = ST_RUN;
                else       state_nx_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_nx_s = ST_DONE;
                else        state_nx_s = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_nx_s = ST_RUN;
                else       state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FIFO storage; stale words are harmless because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= exp_data;
        end
    end

    // FIFO pointers, emptied on reset and whenever a run is armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (arm_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Compare results: saturating counters, run total and first-mismatch capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_r    <= '0;
            pass_cnt_r <= '0;
            fail_cnt_r <= '0;
            err_r      <= 1'b0;
            err_exp_r  <= '0;
            err_obs_r  <= '0;
        end else if (arm_s) begin
            total_r    <= '0;
            pass_cnt_r <= '0;
            fail_cnt_r <= '0;
            err_r      <= 1'b0;
            err_exp_r  <= '0;
            err_obs_r  <= '0;
        end else if (pop_s) begin
            total_r <= total_inc_s;
            if (head_s == obs_data) begin
                if (pass_cnt_r != {CNT_W{1'b1}}) pass_cnt_r <= pass_cnt_r + CNT_ONE;
            end else begin
                if (fail_cnt_r != {CNT_W{1'b1}}) fail_cnt_r <= fail_cnt_r + CNT_ONE;
                if (!err_r) begin
                    err_r     <= 1'b1;
                    err_exp_r <= head_s;
                    err_obs_r <= obs_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_resp_checker.sv
// Randomized and directed bench for resp_checker, scored against a queue-based
// model of the checker's rules.
module tb_resp_checker;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 4;
    localparam int NUM_CHECKS = 16;
    localparam int CNT_W      = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             exp_valid;
    logic             exp_ready;
    logic [WIDTH-1:0] exp_data;
    logic             obs_valid;
    logic             obs_ready;
    logic [WIDTH-1:0] obs_data;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             err;
    logic [WIDTH-1:0] err_exp;
    logic [WIDTH-1:0] err_obs;
    logic             busy;
    logic             done;

    resp_checker #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CHECKS(NUM_CHECKS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
        .obs_valid(obs_valid), .obs_ready(obs_ready), .obs_data(obs_data),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err),
        .err_exp(err_exp), .err_obs(err_obs), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_q[$];
    bit m_run, m_done, m_err;
    int m_pass, m_fail, m_total, m_eexp, m_eobs;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_pass = 0; m_fail = 0; m_total = 0;
        m_err = 1'b0; m_eexp = 0; m_eobs = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_run = 1'b0; m_done = 1'b0;
    endtask

    function automatic bit m_exp_rdy();
        return m_run && (m_q.size() < DEPTH);
    endfunction

    function automatic bit m_obs_rdy();
        return m_run && (m_q.size() > 0);
    endfunction

    task automatic check_all();
        check_val("pass_cnt",  32'(pass_cnt),  32'(m_pass));
        check_val("fail_cnt",  32'(fail_cnt),  32'(m_fail));
        check_val("err",       32'(err),       32'(m_err));
        check_val("err_exp",   32'(err_exp),   32'(m_eexp));
        check_val("err_obs",   32'(err_obs),   32'(m_eobs));
        check_val("busy",      32'(busy),      32'(m_run));
        check_val("done",      32'(done),      32'(m_done));
        check_val("exp_ready", 32'(exp_ready), 32'(m_exp_rdy()));
        check_val("obs_ready", 32'(obs_ready), 32'(m_obs_rdy()));
    endtask

    // One clock: drive inputs, advance the model, then check just after the edge.
    task automatic cyc(input logic st, input logic ev, input logic [7:0] ed,
                       input logic ov, input logic [7:0] od);
        bit er, orr;
        int h;
        start = st; exp_valid = ev; exp_data = ed; obs_valid = ov; obs_data = od;
        er  = m_exp_rdy();
        orr = m_obs_rdy();
        if (m_run) begin
            if (ov && orr) begin
                h = m_q.pop_front();
                m_total++;
                if (h == int'(od)) begin
                    if (m_pass < (1 << CNT_W) - 1) m_pass++;
                end else begin
                    if (m_fail < (1 << CNT_W) - 1) m_fail++;
                    if (!m_err) begin
                        m_err = 1'b1; m_eexp = h; m_eobs = int'(od);
                    end
                end
                if (m_total == NUM_CHECKS) begin
                    m_run = 1'b0; m_done = 1'b1;
                end
            end
            if (ev && er) m_q.push_back(int'(ed));
        end else if (st) begin
            model_clear();
            m_run = 1'b1; m_done = 1'b0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    // n matching pairs, push and pop overlapped in steady state (FIFO assumed empty).
    task automatic run_pairs(input int n);
        logic [7:0] d[16];
        for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
        cyc(1'b0, 1'b1, d[0], 1'b0, 8'h00);
        for (int i = 1; i < n; i++) cyc(1'b0, 1'b1, d[i], 1'b1, d[i-1]);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, d[n-1]);
    endtask

    initial begin
        int k;
        logic [7:0] od;
        model_reset();
        rst_n = 1'b0; start = 1'b0; exp_valid = 1'b0; exp_data = '0;
        obs_valid = 1'b0; obs_data = '0;
        #12;
        check_all();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic in-order matches
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h11, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h22, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h33, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h11);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h22);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h33);
        check_val("t1_pass", 32'(pass_cnt), 32'd3);
        check_val("t1_busy", 32'(busy), 32'd1);

        // Two mismatches, only the first captured
        cyc(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h5A);
        cyc(1'b0, 1'b1, 8'h01, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h02);
        check_val("t2_fail", 32'(fail_cnt), 32'd2);
        check_val("t2_eexp", 32'(err_exp), 32'hA5);
        check_val("t2_eobs", 32'(err_obs), 32'h5A);

        // Fill to full with exp_valid held; the fifth value waits
        k = 0;
        for (int i = 0; i < 6; i++) begin
            bit acc;
            acc = m_exp_rdy();
            cyc(1'b0, 1'b1, 8'(8'h40 + k), 1'b0, 8'h00);
            if (acc) k++;
        end
        check_val("t3_full_rdy", 32'(exp_ready), 32'd0);
        cyc(1'b0, 1'b1, 8'h44, 1'b1, 8'h40);
        check_val("t3_rdy_back", 32'(exp_ready), 32'd1);
        cyc(1'b0, 1'b1, 8'h44, 1'b1, 8'h41);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h42);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h43);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h44);

        // Empty FIFO: no bypass
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h7E);
        cyc(1'b0, 1'b1, 8'h7E, 1'b1, 8'h7E);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h7E);

        // Finish the run (11 compares so far)
        run_pairs(5);
        check_val("r1_done", 32'(done), 32'd1);

        // Full streaming run to done, then rearm
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        run_pairs(16);
        check_val("t5_done", 32'(done), 32'd1);
        check_val("t5_pass", 32'(pass_cnt), 32'd16);
        cyc(1'b0, 1'b1, 8'h55, 1'b1, 8'h55);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        check_val("t5_rearm", 32'(pass_cnt), 32'd0);

        // Asynchronous reset mid-run with a non-empty FIFO
        run_pairs(5);
        cyc(1'b0, 1'b1, 8'hC3, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        run_pairs(16);
        check_val("t6_pass", 32'(pass_cnt), 32'd16);
        check_val("t6_fail", 32'(fail_cnt), 32'd0);

        // Random traffic with occasional rearming
        for (int i = 0; i < 800; i++) begin
            od = 8'($urandom);
            if (m_q.size() > 0 && $urandom_range(3) != 0) od = 8'(m_q[0]);
            cyc(1'(($urandom_range(15) == 0) || (!m_run && $urandom_range(3) == 0)),
                1'($urandom_range(1)), 8'($urandom),
                1'($urandom_range(1)), od);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
